// File: rtl/top_intf.sv
// Transaction front-end: 16-word memory, 8-entry push buffer with read/update/credit channels.
// Define TOP_INTF_SHRINK_EN to let is_shrink remove buffer entries instead of reading them.
module top_intf (
  input  logic        AXI_ACLK,
  input  logic        AXI_ARESETN,
  input  logic        INIT_AXI_TXN,
  input  logic        start_write,
  input  logic [31:0] Addr_write,
  input  logic [31:0] Data_write,
  input  logic        start_read,
  input  logic [31:0] Addr_read,
  output logic        TXN_DONE,
  output logic        ERROR,
  input  logic        read_idx_valid,
  input  logic [7:0]  read_idx,
  output logic        read_idx_ready,
  input  logic        read_will_update,
  input  logic        is_shrink,
  output logic        read_data_valid,
  output logic [31:0] read_data,
  input  logic        read_data_ready,
  input  logic        update_idx_valid,
  input  logic [7:0]  update_idx,
  input  logic        update_data_valid,
  input  logic [31:0] update_data,
  output logic        update_ready,
  output logic        update_receive_ack,
  output logic        credit_valid,
  output logic [7:0]  credit_out,
  input  logic        credit_ready
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        sw_q, sr_q;
  logic [31:0] mem_q [16];
  logic [31:0] mem_d [16];
  logic [31:0] buf_q [8];
  logic [31:0] buf_d [8];
  logic [7:0]  pend_q, pend_d;
  logic [3:0]  count_q, count_d;
  logic        err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        ack_q, ack_d;
  logic        credit_valid_q, credit_valid_d;

  logic sw_edge, sr_edge, rd_resp, shrink_req, idx_ok, upd_ok, upd_hs;

`ifdef TOP_INTF_SHRINK_EN
  assign shrink_req = is_shrink;
`else
  logic unused_is_shrink;
  assign unused_is_shrink = is_shrink;
  assign shrink_req = 1'b0;
`endif

  assign sw_edge = start_write & ~sw_q;
  assign sr_edge = start_read & ~sr_q;
  assign rd_resp = (state_q == StResp) && !is_wr_q;
  assign idx_ok  = read_idx < {4'b0, count_q};
  assign upd_ok  = update_idx < {4'b0, count_q};

  assign read_idx_ready = AXI_ARESETN && !rsp_valid_q && !rd_resp;
  assign update_ready   = AXI_ARESETN && !rd_resp && !(read_idx_valid && shrink_req);
  assign upd_hs         = update_idx_valid && update_data_valid && update_ready;
  assign TXN_DONE       = AXI_ARESETN && (state_q == StResp);

  assign ERROR              = err_q;
  assign read_data_valid    = rsp_valid_q;
  assign read_data          = rsp_data_q;
  assign update_receive_ack = ack_q;
  assign credit_valid       = credit_valid_q;
  assign credit_out         = 8'd8 - {4'b0, count_q};

  always_comb begin
    state_d        = state_q;
    is_wr_d        = is_wr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mem_d          = mem_q;
    buf_d          = buf_q;
    pend_d         = pend_q;
    count_d        = count_q;
    err_d          = err_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    ack_d          = 1'b0;
    credit_valid_d = credit_valid_q;

    case (state_q)
      StIdle: begin
        if (INIT_AXI_TXN) begin
          if (sw_edge) begin
            state_d = StAddr;
            is_wr_d = 1'b1;
            addr_d  = Addr_write;
            wdata_d = Data_write;
          end else if (sr_edge) begin
            if (count_q == 4'd8) begin
              err_d = 1'b1;
            end else begin
              state_d = StAddr;
              is_wr_d = 1'b0;
              addr_d  = Addr_read;
            end
          end
        end
      end
      StAddr: begin
        state_d = StResp;
        if (is_wr_q && (addr_q[31:4] == 28'd0)) mem_d[addr_q[3:0]] = wdata_q;
      end
      StResp: begin
        state_d = StIdle;
        if (addr_q[31:4] != 28'd0) begin
          err_d = 1'b1;
        end else if (!is_wr_q && (count_q < 4'd8)) begin
          buf_d[count_q[2:0]]  = mem_q[addr_q[3:0]];
          pend_d[count_q[2:0]] = 1'b0;
          count_d              = count_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rsp_valid_q && read_data_ready) rsp_valid_d = 1'b0;

    if (read_idx_valid && read_idx_ready) begin
      if (shrink_req) begin
        if (idx_ok) begin
          // Close the gap: every entry above the removed one moves down a slot.
          for (int i = 0; i < 7; i++) begin
            if (3'(i) >= read_idx[2:0]) begin
              buf_d[i]  = buf_q[i+1];
              pend_d[i] = pend_q[i+1];
            end
          end
          buf_d[7]  = '0;
          pend_d[7] = 1'b0;
          count_d   = count_q - 4'd1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        rsp_valid_d = 1'b1;
        if (idx_ok) begin
          rsp_data_d = buf_q[read_idx[2:0]];
          if (read_will_update) pend_d[read_idx[2:0]] = 1'b1;
        end else begin
          rsp_data_d = '0;
          err_d      = 1'b1;
        end
      end
    end

    if (upd_hs) begin
      if (upd_ok) begin
        buf_d[update_idx[2:0]]  = update_data;
        pend_d[update_idx[2:0]] = 1'b0;
        ack_d                   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (count_d != count_q) credit_valid_d = 1'b1;
    else if (credit_ready) credit_valid_d = 1'b0;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      state_q        <= StIdle;
      is_wr_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      sw_q           <= 1'b0;
      sr_q           <= 1'b0;
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      pend_q         <= '0;
      count_q        <= '0;
      err_q          <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      ack_q          <= 1'b0;
      credit_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_wr_q        <= is_wr_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      sw_q           <= start_write;
      sr_q           <= start_read;
      mem_q          <= mem_d;
      buf_q          <= buf_d;
      pend_q         <= pend_d;
      count_q        <= count_d;
      err_q          <= err_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      ack_q          <= ack_d;
      credit_valid_q <= credit_valid_d;
    end
  end

endmodule

// File: tb/tb_top_intf.sv
// Directed bench for top_intf: vector table for the main flow plus hand-written corner sequences.
module tb_top_intf;

  logic        AXI_ACLK = 1'b0;
  logic        AXI_ARESETN;
  logic        INIT_AXI_TXN;
  logic        start_write;
  logic [31:0] Addr_write;
  logic [31:0] Data_write;
  logic        start_read;
  logic [31:0] Addr_read;
  logic        TXN_DONE;
  logic        ERROR;
  logic        read_idx_valid;
  logic [7:0]  read_idx;
  logic        read_idx_ready;
  logic        read_will_update;
  logic        is_shrink;
  logic        read_data_valid;
  logic [31:0] read_data;
  logic        read_data_ready;
  logic        update_idx_valid;
  logic [7:0]  update_idx;
  logic        update_data_valid;
  logic [31:0] update_data;
  logic        update_ready;
  logic        update_receive_ack;
  logic        credit_valid;
  logic [7:0]  credit_out;
  logic        credit_ready;

  top_intf dut (
    .AXI_ACLK          (AXI_ACLK),
    .AXI_ARESETN       (AXI_ARESETN),
    .INIT_AXI_TXN      (INIT_AXI_TXN),
    .start_write       (start_write),
    .Addr_write        (Addr_write),
    .Data_write        (Data_write),
    .start_read        (start_read),
    .Addr_read         (Addr_read),
    .TXN_DONE          (TXN_DONE),
    .ERROR             (ERROR),
    .read_idx_valid    (read_idx_valid),
    .read_idx          (read_idx),
    .read_idx_ready    (read_idx_ready),
    .read_will_update  (read_will_update),
    .is_shrink         (is_shrink),
    .read_data_valid   (read_data_valid),
    .read_data         (read_data),
    .read_data_ready   (read_data_ready),
    .update_idx_valid  (update_idx_valid),
    .update_idx        (update_idx),
    .update_data_valid (update_data_valid),
    .update_data       (update_data),
    .update_ready      (update_ready),
    .update_receive_ack(update_receive_ack),
    .credit_valid      (credit_valid),
    .credit_out        (credit_out),
    .credit_ready      (credit_ready)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  localparam int OpWr  = 0;
  localparam int OpRd  = 1;
  localparam int OpBuf = 2;
  localparam int OpUpd = 3;

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];
  int   checks   = 0;
  int   failures = 0;

`ifdef TOP_INTF_SHRINK_EN
  localparam bit ShrinkEn = 1'b1;
`else
  localparam bit ShrinkEn = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge AXI_ACLK);
    #1;
  endtask

  task automatic txn(input bit wr, input bit rd, input logic [31:0] addr,
                     input logic [31:0] data, output int done_at, output int done_cnt);
    done_at  = 0;
    done_cnt = 0;
    if (wr) begin
      Addr_write  = addr;
      Data_write  = data;
      start_write = 1'b1;
    end
    if (rd) begin
      Addr_read  = addr;
      start_read = 1'b1;
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin
        start_write = 1'b0;
        start_read  = 1'b0;
      end
      if (TXN_DONE) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
    end
  endtask

  task automatic consume_credit();
    credit_ready = 1'b1;
    tick();
    credit_ready = 1'b0;
  endtask

  task automatic buf_rd(input logic [7:0] idx, input bit shr, output logic rdy,
                        output logic vld, output logic [31:0] data);
    rdy            = read_idx_ready;
    read_idx_valid = 1'b1;
    read_idx       = idx;
    is_shrink      = shr;
    tick();
    read_idx_valid = 1'b0;
    is_shrink      = 1'b0;
    vld            = read_data_valid;
    data           = read_data;
    if (vld) begin
      read_data_ready = 1'b1;
      tick();
      read_data_ready = 1'b0;
    end
  endtask

  task automatic upd(input logic [7:0] idx, input logic [31:0] data, output logic ur,
                     output int acks);
    ur                = update_ready;
    update_idx_valid  = 1'b1;
    update_data_valid = 1'b1;
    update_idx        = idx;
    update_data       = data;
    tick();
    update_idx_valid  = 1'b0;
    update_data_valid = 1'b0;
    acks              = int'(update_receive_ack);
    tick();
    acks += int'(update_receive_ack);
  endtask

  task automatic do_reset();
    AXI_ARESETN = 1'b0;
    tick();
    tick();
    AXI_ARESETN = 1'b1;
  endtask

  initial begin
    int          at, cnt, acks;
    logic        rdy, vld, ur;
    logic [31:0] data;

    vecs[0]  = '{OpWr,  32'd1, 32'h11,         32'd0};
    vecs[1]  = '{OpRd,  32'd1, 32'd0,          32'd7};
    vecs[2]  = '{OpRd,  32'd2, 32'd0,          32'd6};
    vecs[3]  = '{OpBuf, 32'd0, 32'd0,          32'h11};
    vecs[4]  = '{OpBuf, 32'd1, 32'd0,          32'h10};
    vecs[5]  = '{OpUpd, 32'd0, 32'h21,         32'd0};
    vecs[6]  = '{OpBuf, 32'd0, 32'd0,          32'h21};
    vecs[7]  = '{OpWr,  32'd5, 32'hDEADBEEF,   32'd0};
    vecs[8]  = '{OpRd,  32'd5, 32'd0,          32'd5};
    vecs[9]  = '{OpBuf, 32'd2, 32'd0,          32'hDEADBEEF};
    vecs[10] = '{OpRd,  32'd3, 32'd0,          32'd4};
    vecs[11] = '{OpBuf, 32'd3, 32'd0,          32'd0};
    vecs[12] = '{OpUpd, 32'd3, 32'hCAFE0003,   32'd0};
    vecs[13] = '{OpBuf, 32'd3, 32'd0,          32'hCAFE0003};

    AXI_ARESETN       = 1'b0;
    INIT_AXI_TXN      = 1'b1;
    start_write       = 1'b1;
    Addr_write        = 32'd2;
    Data_write        = 32'h10;
    start_read        = 1'b0;
    Addr_read         = '0;
    read_idx_valid    = 1'b0;
    read_idx          = '0;
    read_will_update  = 1'b0;
    is_shrink         = 1'b0;
    read_data_ready   = 1'b0;
    update_idx_valid  = 1'b0;
    update_idx        = '0;
    update_data_valid = 1'b0;
    update_data       = '0;
    credit_ready      = 1'b0;

    // Reset values, with start_write held high through reset.
    tick(); tick(); tick();
    check("rst_txn_done", TXN_DONE, 0);
    check("rst_error", ERROR, 0);
    check("rst_rd_valid", read_data_valid, 0);
    check("rst_rd_data", read_data, 0);
    check("rst_ack", update_receive_ack, 0);
    check("rst_credit_valid", credit_valid, 0);
    check("rst_credit_out", credit_out, 8);
    check("rst_idx_ready", read_idx_ready, 0);
    check("rst_upd_ready", update_ready, 0);

    AXI_ARESETN = 1'b1;
    at = 0; cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) start_write = 1'b0;
      if (TXN_DONE) begin
        cnt++;
        if (at == 0) at = k;
      end
    end
    check("held_edge_done_cnt", cnt, 1);
    check("held_edge_done_at", at, 2);

    for (int i = 0; i < 14; i++) begin
      case (vecs[i].op)
        OpWr: begin
          txn(1'b1, 1'b0, vecs[i].a, vecs[i].d, at, cnt);
          check($sformatf("v%0d_wr_done_at", i), at, 2);
          check($sformatf("v%0d_wr_done_cnt", i), cnt, 1);
        end
        OpRd: begin
          txn(1'b0, 1'b1, vecs[i].a, 32'd0, at, cnt);
          check($sformatf("v%0d_rd_done_at", i), at, 2);
          check($sformatf("v%0d_credit_valid", i), credit_valid, 1);
          check($sformatf("v%0d_credit_out", i), credit_out, vecs[i].exp);
          consume_credit();
        end
        OpBuf: begin
          buf_rd(vecs[i].a[7:0], 1'b0, rdy, vld, data);
          check($sformatf("v%0d_idx_ready", i), rdy, 1);
          check($sformatf("v%0d_rd_valid", i), vld, 1);
          check($sformatf("v%0d_rd_data", i), data, vecs[i].exp);
        end
        default: begin
          upd(vecs[i].a[7:0], vecs[i].d, ur, acks);
          check($sformatf("v%0d_upd_ready", i), ur, 1);
          check($sformatf("v%0d_ack_cnt", i), acks, 1);
        end
      endcase
      check($sformatf("v%0d_error", i), ERROR, 0);
    end

    // Response held while consumer stalls; request side blocked meanwhile.
    read_idx_valid = 1'b1;
    read_idx       = 8'd1;
    tick();
    read_idx_valid = 1'b0;
    read_idx       = 8'd2;
    check("hold_valid0", read_data_valid, 1);
    check("hold_data0", read_data, 32'h10);
    check("hold_idx_ready", read_idx_ready, 0);
    tick(); tick();
    check("hold_valid2", read_data_valid, 1);
    check("hold_data2", read_data, 32'h10);
    read_data_ready = 1'b1;
    tick();
    read_data_ready = 1'b0;
    check("hold_released", read_data_valid, 0);
    check("hold_idx_ready_back", read_idx_ready, 1);

    // Simultaneous edges: write wins, read dropped.
    txn(1'b1, 1'b1, 32'd6, 32'h66, at, cnt);
    check("both_done_cnt", cnt, 1);
    check("both_no_push", credit_valid, 0);
    txn(1'b0, 1'b1, 32'd6, 32'd0, at, cnt);
    check("both_credit_out", credit_out, 3);
    consume_credit();
    buf_rd(8'd4, 1'b0, rdy, vld, data);
    check("both_mem6", data, 32'h66);

    // Read edge while busy is dropped.
    Addr_write  = 32'd7;
    Data_write  = 32'h77;
    start_write = 1'b1;
    tick();
    start_write = 1'b0;
    Addr_read   = 32'd7;
    start_read  = 1'b1;
    tick();
    start_read  = 1'b0;
    cnt = int'(TXN_DONE);
    for (int k = 0; k < 4; k++) begin
      tick();
      cnt += int'(TXN_DONE);
    end
    check("busy_done_cnt", cnt, 1);
    check("busy_no_push", credit_valid, 0);

    // INIT_AXI_TXN low blocks starts; the held level is not an edge later.
    INIT_AXI_TXN = 1'b0;
    start_read   = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      cnt += int'(TXN_DONE);
    end
    INIT_AXI_TXN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      cnt += int'(TXN_DONE);
    end
    start_read = 1'b0;
    tick();
    check("init_low_done_cnt", cnt, 0);
    check("init_low_no_push", credit_valid, 0);

    // Read RESP cycle gating, then credit hold.
    Addr_read  = 32'd7;
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    check("addr_idx_ready", read_idx_ready, 1);
    tick();
    check("resp_done", TXN_DONE, 1);
    check("resp_idx_ready", read_idx_ready, 0);
    check("resp_upd_ready", update_ready, 0);
    tick();
    check("push_credit_valid", credit_valid, 1);
    check("push_credit_out", credit_out, 2);
    tick();
    check("credit_held", credit_valid, 1);
    consume_credit();
    check("credit_consumed", credit_valid, 0);
    buf_rd(8'd5, 1'b0, rdy, vld, data);
    check("push_mem7", data, 32'h77);

    // is_shrink on entry 0: removes it when enabled, plain read otherwise.
    read_idx_valid = 1'b1;
    is_shrink      = 1'b1;
    read_idx       = 8'd0;
    #1;
    check("shrink_upd_ready", update_ready, ShrinkEn ? 0 : 1);
    tick();
    read_idx_valid = 1'b0;
    is_shrink      = 1'b0;
    if (ShrinkEn) begin
      check("shrink_no_rsp", read_data_valid, 0);
      check("shrink_credit_valid", credit_valid, 1);
      check("shrink_credit_out", credit_out, 3);
      consume_credit();
      buf_rd(8'd0, 1'b0, rdy, vld, data);
      check("shrink_shifted", data, 32'h10);
    end else begin
      check("noshrink_rsp", read_data_valid, 1);
      check("noshrink_data", read_data, 32'h21);
      check("noshrink_no_credit", credit_valid, 0);
      read_data_ready = 1'b1;
      tick();
      read_data_ready = 1'b0;
    end

    // Out-of-range write address: error, done, memory untouched.
    txn(1'b1, 1'b0, 32'h20, 32'h55, at, cnt);
    check("badwr_done_at", at, 2);
    check("badwr_error", ERROR, 1);
    txn(1'b0, 1'b1, 32'd0, 32'd0, at, cnt);
    check("badwr_credit_out", credit_out, ShrinkEn ? 2 : 1);
    consume_credit();
    buf_rd(ShrinkEn ? 8'd5 : 8'd6, 1'b0, rdy, vld, data);
    check("badwr_mem0", data, 0);

    // Reset in the ADDR cycle aborts the write without TXN_DONE.
    Addr_write  = 32'd4;
    Data_write  = 32'h44;
    start_write = 1'b1;
    tick();
    start_write = 1'b0;
    AXI_ARESETN = 1'b0;
    cnt = 0;
    tick();
    cnt += int'(TXN_DONE);
    tick();
    cnt += int'(TXN_DONE);
    AXI_ARESETN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      cnt += int'(TXN_DONE);
    end
    check("abort_no_done", cnt, 0);
    check("abort_error_clr", ERROR, 0);
    check("abort_credit_out", credit_out, 8);

    // Buffer read past count returns 0 and flags error.
    txn(1'b1, 1'b0, 32'd9, 32'h99, at, cnt);
    txn(1'b0, 1'b1, 32'd9, 32'd0, at, cnt);
    consume_credit();
    txn(1'b0, 1'b1, 32'd9, 32'd0, at, cnt);
    consume_credit();
    check("oor_pre_error", ERROR, 0);
    buf_rd(8'd9, 1'b0, rdy, vld, data);
    check("oor_valid", vld, 1);
    check("oor_data", data, 0);
    check("oor_error", ERROR, 1);

    // Update past count: no ack, error.
    do_reset();
    upd(8'd0, 32'h12, ur, acks);
    check("upd_oor_ack", acks, 0);
    check("upd_oor_error", ERROR, 1);

    // Fill to 8, then a further read edge is dropped with error.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      txn(1'b0, 1'b1, 32'(i), 32'd0, at, cnt);
      check($sformatf("fill%0d_credit", i), credit_out, 32'(7 - i));
      consume_credit();
    end
    check("full_pre_error", ERROR, 0);
    txn(1'b0, 1'b1, 32'd1, 32'd0, at, cnt);
    check("full_no_done", cnt, 0);
    check("full_error", ERROR, 1);
    check("full_no_credit", credit_valid, 0);

    // Out-of-range read address: done, error, no push.
    do_reset();
    txn(1'b0, 1'b1, 32'h100, 32'd0, at, cnt);
    check("badrd_done_cnt", cnt, 1);
    check("badrd_error", ERROR, 1);
    check("badrd_no_push", credit_valid, 0);
    check("badrd_credit_out", credit_out, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/top_intf.md
TOP_INTF -- requirements
Module: top_intf
Interface
REQ-001 AXI_ACLK  in  1  sole clock; all logic SHALL use its rising edge.
REQ-002 AXI_ARESETN  in  1  synchronous, active-low reset.
REQ-003 INIT_AXI_TXN  in  1  level enable; while 0, no new memory transaction SHALL start.
REQ-004 start_write  in  1  write request, rising-edge detected.
REQ-005 Addr_write  in  32  memory word address for write.
REQ-006 Data_write  in  32  write data.
REQ-007 start_read  in  1  read-and-push request, rising-edge detected.
REQ-008 Addr_read  in  32  memory word address for read.
REQ-009 TXN_DONE  out  1  one-cycle pulse at the end of each memory transaction.
REQ-010 ERROR  out  1  sticky error flag.
REQ-011 read_idx_valid  in  1  buffer read/shrink request valid.
REQ-012 read_idx  in  8  buffer entry index.
REQ-013 read_idx_ready  out  1  read request acceptance.
REQ-014 read_will_update  in  1  qualifier: mark the read entry pending-update.
REQ-015 is_shrink  in  1  qualifier: remove the entry instead of reading it.
REQ-016 read_data_valid  out  1  read response valid.
REQ-017 read_data  out  32  read response data.
REQ-018 read_data_ready  in  1  read response consumer ready.
REQ-019 update_idx_valid  in  1  update index valid.
REQ-020 update_idx  in  8  entry to overwrite.
REQ-021 update_data_valid  in  1  update data valid.
REQ-022 update_data  in  32  replacement data.
REQ-023 update_ready  out  1  update channel can accept.
REQ-024 update_receive_ack  out  1  one-cycle pulse per accepted update.
REQ-025 credit_valid  out  1  credit report valid.
REQ-026 credit_out  out  8  free buffer entries.
REQ-027 credit_ready  in  1  credit consumer ready.
Function
REQ-028 Storage:
- memory of 16x32 words, addressed by Addr[3:0].
- buffer of 8x32 entries 0..count-1; each entry has a pending bit; count ranges 0..8.
REQ-029 Transaction FSM IDLE->ADDR->RESP->IDLE:
- Starts from IDLE only while INIT_AXI_TXN=1, on a start_write edge or a start_read edge.
- If both edges occur in the same cycle, write wins.
- Edges arriving while busy or while INIT_AXI_TXN=0 are dropped.
REQ-030 Write: memory is written in ADDR; TXN_DONE pulses in RESP, i.e. 2 cycles after the edge-detect cycle.
REQ-031 Read:
- In RESP, mem[Addr_read[3:0]] is appended at buffer[count]; count increments; pending bit cleared; TXN_DONE pulses.
- A start_read edge arriving with count=8 is dropped and sets ERROR.
REQ-032 Address with Addr[31:4]!=0: no memory access and no push; TXN_DONE still pulses; ERROR is set.
REQ-033 Read request and response:
- read_idx_ready=1 when no response is outstanding and the FSM is not in a read RESP cycle.
- A handshake with is_shrink=0 gives read_data_valid=1 next cycle with read_data=buffer[read_idx], held stable until read_data_ready.
- The pending bit is set if read_will_update=1.
- read_idx>=count returns 0 with valid and sets ERROR.
REQ-034 Shrink:
- A handshake with is_shrink=1 removes entry read_idx; higher entries shift down one; count decrements; no response is produced.
- read_idx>=count: ignored, and ERROR is set.
REQ-035 Update:
- update_ready=0 during a read RESP cycle and while read_idx_valid&&is_shrink; otherwise 1.
- Accepted when update_idx_valid&&update_data_valid&&update_ready: buffer[update_idx]=update_data; pending cleared; update_receive_ack pulses next cycle.
- update_idx>=count: no write, no ack, ERROR set.
REQ-036 Credit:
- After any count change, credit_valid=1 next cycle with credit_out=8-count.
- credit_valid is held until credit_ready.
- Later changes while credit_valid=1 refresh credit_out.
Reset
REQ-037 Values while AXI_ARESETN=0:
- TXN_DONE, ERROR, read_data_valid, read_data, update_receive_ack, credit_valid, read_idx_ready, update_ready = 0; credit_out=8.
- Memory, buffer, pending bits, count, FSM state and edge-detect registers are cleared.
REQ-038 Reset release:
- An input held high through reset SHALL be seen as a rising edge in the first cycle after release.
- Reset mid-transaction SHALL abort the transaction with no memory write and no TXN_DONE.
Configuration
REQ-039 With TOP_INTF_SHRINK_EN defined, shrink SHALL behave per REQ-034.
REQ-040 Without TOP_INTF_SHRINK_EN: is_shrink SHALL be ignored (the request is treated as a normal read); update_ready is then unaffected by is_shrink.
Verification
REQ-041 start_write held 1 through reset, Addr_write=2, Data_write=0x10 -> after release, mem[2]=0x10 and TXN_DONE pulses once.
REQ-042 Write mem[1]=0x11; start_read with Addr_read=1, then with Addr_read=2 -> buffer[0]=0x11, buffer[1]=0x10; credit_out reports 7, then 6.
REQ-043 read_idx=1, read_idx_valid pulse -> read_data=0x10 next cycle; with read_data_ready=0 it holds and read_idx_ready=0.
REQ-044 Update update_idx=0 with 0x21 -> update_receive_ack pulse; a read of idx 0 returns 0x21 with pending cleared.
REQ-045 Shrink idx 0 -> count=1, buffer[0]=0x10, credit_out=7.
REQ-046 Addr_write=0x20 write -> ERROR=1, TXN_DONE pulses, memory unchanged.
